router_reg_param: RTL and testbench

//  Parametrised router datapath register stage between the input port and the per-channel output FIFOs.

---
 rtl/router_reg_param.sv | 225 ++++++++++++++++++++++
 tb/tb_router_reg_param.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_reg_param.sv
// Router datapath register stage: header capture, byte streaming to the
// destination FIFO, a small holding buffer used while that FIFO is full,
// and running XOR parity checking against the packet parity byte.
// Optional build macro ROUTER_REG_LEN_CHK_EN adds a payload length check.
module router_reg_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned HOLD_DEPTH = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              hold_empty,
  output logic              hold_ovf,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  localparam int unsigned PtrW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(HOLD_DEPTH + 1);
  localparam int unsigned LenW = DATA_W - ADDR_W;

  logic [DATA_W-1:0] hdr_q, hdr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0] hold_mem_q [HOLD_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   occ_q, occ_d;
  logic [DATA_W-1:0] int_par_q, int_par_d;
  logic [DATA_W-1:0] pkt_par_q, pkt_par_d;
  logic              parity_done_q, parity_done_d;
  logic              parity_done_dly_q;
  logic              low_pkt_valid_q, low_pkt_valid_d;
  logic              hold_ovf_q, hold_ovf_d;
  logic              err_q, err_d;

  logic addr_ok;
  logic hold_is_empty;
  logic hold_is_full;
  logic push;
  logic pop;
  logic drop;
  logic accept;
  logic err_eval;
  logic mismatch;

`ifdef ROUTER_REG_LEN_CHK_EN
  logic [LenW-1:0] len_cnt_q, len_cnt_d;
`endif

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(HOLD_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign addr_ok       = 32'(data_in[ADDR_W-1:0]) < NUM_CH;
  assign hold_is_empty = (occ_q == '0);
  assign hold_is_full  = (occ_q == CntW'(HOLD_DEPTH));
  // Bytes that enter the packet stream (written or held); dropped ones do not count.
  assign accept        = ld_state & pkt_valid & ~full_state & ~drop;
  // Single-cycle strobe on the first cycle parity_done is visible.
  assign err_eval      = parity_done_q & ~parity_done_dly_q;

  // Header capture, output byte selection and holding-buffer push/pop decisions
  always_comb begin
    hdr_d        = hdr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    drop         = 1'b0;
    if (detect_add && pkt_valid && addr_ok) begin
      hdr_d = data_in;
    end
    if (lfd_state) begin
      dout_d       = hdr_q;
      dout_valid_d = 1'b1;
    end else if (ld_state && !fifo_full && hold_is_empty) begin
      dout_d       = data_in;
      dout_valid_d = 1'b1;
    end else if (ld_state) begin
      // Once anything is held, later bytes queue behind it to keep order.
      if (hold_is_full) begin
        drop = 1'b1;
      end else begin
        push = 1'b1;
      end
    end else if (laf_state && !fifo_full && !hold_is_empty) begin
      pop          = 1'b1;
      dout_d       = hold_mem_q[rd_ptr_q];
      dout_valid_d = 1'b1;
    end
  end

  // Holding-buffer pointers and occupancy
  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + CntW'(1);
      2'b01:   occ_d = occ_q - CntW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Parity accumulation, status flags and error evaluation
  always_comb begin
    int_par_d       = int_par_q;
    pkt_par_d       = pkt_par_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;
    hold_ovf_d      = hold_ovf_q;
    err_d           = err_q;
    mismatch        = (pkt_par_q != int_par_q) | hold_ovf_q;
`ifdef ROUTER_REG_LEN_CHK_EN
    len_cnt_d = len_cnt_q;
    if (detect_add) begin
      len_cnt_d = '0;
    end else if (accept && !(&len_cnt_q)) begin
      len_cnt_d = len_cnt_q + LenW'(1);
    end
    mismatch = mismatch | (len_cnt_q != hdr_q[DATA_W-1:ADDR_W]);
`endif
    if (detect_add) begin
      int_par_d = '0;
    end else if (lfd_state) begin
      int_par_d = int_par_q ^ hdr_q;
    end else if (accept) begin
      int_par_d = int_par_q ^ data_in;
    end
    if (ld_state && !pkt_valid) begin
      pkt_par_d       = data_in;
      parity_done_d   = 1'b1;
      low_pkt_valid_d = 1'b1;
    end
    if (detect_add) begin
      parity_done_d = 1'b0;
      hold_ovf_d    = 1'b0;
    end
    if (drop) begin
      hold_ovf_d = 1'b1;
    end
    if (rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end
    if (err_eval) begin
      err_d = mismatch;
    end
    if (rst_int_reg || detect_add) begin
      err_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      hdr_q             <= '0;
      dout_q            <= '0;
      dout_valid_q      <= 1'b0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      occ_q             <= '0;
      int_par_q         <= '0;
      pkt_par_q         <= '0;
      parity_done_q     <= 1'b0;
      parity_done_dly_q <= 1'b0;
      low_pkt_valid_q   <= 1'b0;
      hold_ovf_q        <= 1'b0;
      err_q             <= 1'b0;
    end else begin
      hdr_q             <= hdr_d;
      dout_q            <= dout_d;
      dout_valid_q      <= dout_valid_d;
      wr_ptr_q          <= wr_ptr_d;
      rd_ptr_q          <= rd_ptr_d;
      occ_q             <= occ_d;
      int_par_q         <= int_par_d;
      pkt_par_q         <= pkt_par_d;
      parity_done_q     <= parity_done_d;
      parity_done_dly_q <= parity_done_q;
      low_pkt_valid_q   <= low_pkt_valid_d;
      hold_ovf_q        <= hold_ovf_d;
      err_q             <= err_d;
    end
  end

`ifdef ROUTER_REG_LEN_CHK_EN
  // Accepted payload byte counter
  always_ff @(posedge clk) begin
    if (!resetn) begin
      len_cnt_q <= '0;
    end else begin
      len_cnt_q <= len_cnt_d;
    end
  end
`endif

  // Holding-buffer storage; contents are don't-care while empty, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      hold_mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign hold_empty    = hold_is_empty;
  assign hold_ovf      = hold_ovf_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;

endmodule

// File: tb/tb_router_reg_param.sv
// Scoreboard bench for router_reg_param. The bench plays the router FSM by
// driving the state strobes, keeps a packet-level reference model, and a
// separate monitor checks every FIFO write against the expected byte queue.
module tb_router_reg_param;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 2;
  localparam int unsigned NUM_CH     = 3;
  localparam int unsigned HOLD_DEPTH = 2;

  logic       clk = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       dout_valid;
  logic       hold_empty;
  logic       hold_ovf;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       err;

  router_reg_param #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .NUM_CH    (NUM_CH),
    .HOLD_DEPTH(HOLD_DEPTH)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .pkt_valid    (pkt_valid),
    .data_in      (data_in),
    .fifo_full    (fifo_full),
    .detect_add   (detect_add),
    .lfd_state    (lfd_state),
    .ld_state     (ld_state),
    .laf_state    (laf_state),
    .full_state   (full_state),
    .rst_int_reg  (rst_int_reg),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .hold_empty   (hold_empty),
    .hold_ovf     (hold_ovf),
    .parity_done  (parity_done),
    .low_pkt_valid(low_pkt_valid),
    .err          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] sb[$];       // expected FIFO write stream
  logic [7:0] hq[$];       // modelled holding buffer
  logic [7:0] pay_q[$];    // payload of the packet being sent
  logic [7:0] hdr_m;
  logic [7:0] ipar_m;
  logic [7:0] ppar_m;
  logic       ovf_m;
  int         acc_m;
  logic [7:0] mon_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor: every FIFO write must match the next expected byte
  always @(negedge clk) begin
    if (dout_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dout_unexpected: got write of %0h, required no write", dout);
      end else begin
        mon_exp = sb.pop_front();
        check("dout", 32'(dout), 32'(mon_exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    fifo_full   = 1'b0;
    pkt_valid   = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_valid", 32'(dout_valid), 32'd0);
    check("rst_hold_empty", 32'(hold_empty), 32'd1);
    check("rst_hold_ovf", 32'(hold_ovf), 32'd0);
    check("rst_parity_done", 32'(parity_done), 32'd0);
    check("rst_low_pkt_valid", 32'(low_pkt_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  task automatic do_hdr(input logic [7:0] h);
    clear_strobes();
    detect_add = 1'b1;
    pkt_valid  = 1'b1;
    data_in    = h;
    if (32'(h[1:0]) < NUM_CH) hdr_m = h;
    ipar_m = 8'h00;
    ovf_m  = 1'b0;
    acc_m  = 0;
    step();
    check("hdr_no_write", 32'(dout_valid), 32'd0);
    check("hdr_pd_clr", 32'(parity_done), 32'd0);
    check("hdr_ovf_clr", 32'(hold_ovf), 32'd0);
    check("hdr_err_clr", 32'(err), 32'd0);
  endtask

  task automatic do_lfd();
    clear_strobes();
    lfd_state = 1'b1;
    pkt_valid = 1'b1;
    data_in   = 8'($urandom);
    sb.push_back(hdr_m);
    ipar_m ^= hdr_m;
    step();
  endtask

  task automatic do_byte(input logic [7:0] b, input logic pv, input logic full);
    logic kept;
    clear_strobes();
    ld_state  = 1'b1;
    pkt_valid = pv;
    data_in   = b;
    fifo_full = full;
    kept      = 1'b1;
    if (full || hq.size() != 0) begin
      if (hq.size() < HOLD_DEPTH) hq.push_back(b);
      else begin
        kept  = 1'b0;
        ovf_m = 1'b1;
      end
    end else begin
      sb.push_back(b);
    end
    if (pv && kept) begin
      ipar_m ^= b;
      acc_m++;
    end
    if (!pv) ppar_m = b;
    step();
  endtask

  task automatic drain_one();
    clear_strobes();
    laf_state = 1'b1;
    sb.push_back(hq.pop_front());
    step();
  endtask

  task automatic idle();
    clear_strobes();
    step();
  endtask

  // par_mode: 0 correct parity, 1 forced par_val, 2 random corruption.
  // Bytes s..s+m-1 are sent while the FIFO reports full.
  task automatic send_packet(input logic [5:0] len_f, input logic [1:0] addr,
                             input int par_mode, input logic [7:0] par_val,
                             input int s, input int m);
    logic [7:0] h;
    logic [7:0] par;
    logic       exp_err;
    int         total;
    h   = {len_f, addr};
    par = h;
    foreach (pay_q[i]) par ^= pay_q[i];
    if (par_mode == 1) par = par_val;
    else if (par_mode == 2) par = par ^ 8'($urandom_range(1, 255));
    total = pay_q.size() + 1;
    do_hdr(h);
    do_lfd();
    for (int i = 0; i < total; i++) begin
      do_byte((i < pay_q.size()) ? pay_q[i] : par, i < pay_q.size(), i >= s && i < s + m);
      if (i == s + m - 1 && i < total - 1 && hq.size() != 0) begin
        while (hq.size() != 0) drain_one();
        check("mid_hold_empty", 32'(hold_empty), 32'd1);
      end
    end
    check("parity_done", 32'(parity_done), 32'd1);
    check("low_pkt_valid", 32'(low_pkt_valid), 32'd1);
    check("err_before_eval", 32'(err), 32'd0);
    exp_err = (ppar_m != ipar_m) | ovf_m;
`ifdef ROUTER_REG_LEN_CHK_EN
    exp_err = exp_err | (acc_m != int'(hdr_m[7:2]));
`endif
    if (hq.size() != 0) drain_one();
    else idle();
    check("err", 32'(err), 32'(exp_err));
    check("hold_ovf", 32'(hold_ovf), 32'(ovf_m));
    while (hq.size() != 0) drain_one();
    idle();
    check("end_hold_empty", 32'(hold_empty), 32'd1);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("err_held", 32'(err), 32'(exp_err));
    clear_strobes();
    rst_int_reg = 1'b1;
    step();
    check("rst_int_err", 32'(err), 32'd0);
    check("rst_int_lpv", 32'(low_pkt_valid), 32'd0);
    clear_strobes();
  endtask

  initial begin
    int n;
    int s;
    int m;
    logic [5:0] lenf;
    clear_strobes();
    data_in = 8'h00;
    resetn  = 1'b0;
    hdr_m   = 8'h00;
    step();
    step();
    check_reset_outputs();
    resetn = 1'b1;

    // Clean packet, then the same packet with a bad parity byte
    pay_q = '{8'h11, 8'h22, 8'h33};
    send_packet(6'd3, 2'd1, 0, 8'h00, 0, 0);
    send_packet(6'd3, 2'd1, 1, 8'hFF, 0, 0);
    // FIFO full for two bytes mid-payload, then for three bytes (overflow)
    send_packet(6'd3, 2'd1, 0, 8'h00, 1, 2);
    send_packet(6'd3, 2'd1, 0, 8'h00, 0, 3);
    // Length field vs payload count
    pay_q = '{8'hA5, 8'h5A};
    send_packet(6'd3, 2'd0, 0, 8'h00, 0, 0);
    pay_q = '{8'hA5, 8'h5A, 8'h3C};
    send_packet(6'd3, 2'd0, 0, 8'h00, 0, 0);

    // Illegal address: header register keeps the last legal header
    do_hdr(8'h0F);
    do_lfd();
    idle();
    check("illegal_sb_drained", 32'(sb.size()), 32'd0);

    // Reset in the middle of a payload with bytes held
    pay_q = '{8'h77, 8'h88};
    do_hdr(8'h0A);
    do_lfd();
    do_byte(8'h77, 1'b1, 1'b0);
    do_byte(8'h88, 1'b1, 1'b1);
    check("pre_rst_hold_busy", 32'(hold_empty), 32'd0);
    clear_strobes();
    resetn = 1'b0;
    step();
    hq.delete();
    check_reset_outputs();
    check("rst_sb_drained", 32'(sb.size()), 32'd0);
    resetn = 1'b1;
    idle();

    // Randomized packets
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(1, 6);
      pay_q.delete();
      for (int j = 0; j < n; j++) pay_q.push_back(8'($urandom));
      lenf = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'(n);
      if ($urandom_range(0, 1) == 1) begin
        s = $urandom_range(0, n);
        m = $urandom_range(1, 3);
      end else begin
        s = 0;
        m = 0;
      end
      send_packet(lenf, 2'($urandom_range(0, 2)), ($urandom_range(0, 3) == 0) ? 2 : 0,
                  8'h00, s, m);
    end

    idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
